pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, program-counter and stack-entry width in bits.
REQ-002 Parameter STACK_DEPTH, default 8, number of return-address entries, legal range 2..64.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cen  input  1  increment request.
REQ-006 ld  input  1  absolute load request (jump).
REQ-007 call  input  1  call request: push return address, jump.
REQ-008 ret  input  1  return request: pop, jump to popped address.
REQ-009 clr_err  input  1  clear sticky error flags.
REQ-010 in  input  ADDR_WIDTH  jump/call target.
REQ-011 out  output  ADDR_WIDTH  current PC.
REQ-012 depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
REQ-013 full  output  1  depth == STACK_DEPTH.
REQ-014 empty  output  1  depth == 0.
REQ-015 overflow  output  1  sticky: call attempted while full.
REQ-016 underflow  output  1  sticky: ret attempted while empty.

Function
REQ-017 One operation per cycle; fixed priority ret > call > ld > cen; lower-priority requests in the same cycle are ignored.
REQ-018 cen: out <= out + 1, modulo 2^ADDR_WIDTH (all-ones wraps to 0).
REQ-019 ld: out <= in; stack untouched.
REQ-020 call when not full: stack[depth] <= out + 1 (modulo 2^ADDR_WIDTH); depth <= depth + 1; out <= in.
REQ-021 call when full: out, stack and depth unchanged; overflow <= 1.
REQ-022 ret when not empty: out <= stack[depth-1]; depth <= depth - 1.
REQ-023 ret when empty: out and depth unchanged; underflow <= 1.
REQ-024 No request asserted: all state holds.
REQ-025 Latency: out, depth, full and empty reflect an operation on the clock edge that samples it; no combinational path from request inputs to outputs.
REQ-026 full and empty are decoded from registered depth.
REQ-027 clr_err clears overflow and underflow on the next edge; if an error is set in the same cycle, the set wins.
REQ-028 Stack entries above depth hold stale data and are never observable on out.

Reset
REQ-029 rst low asynchronously forces out=0, depth=0, overflow=0, underflow=0, regardless of clk or other inputs.
REQ-030 Reset asserted mid-sequence discards all stacked addresses; stack storage contents need not be cleared.
REQ-031 After rst deasserts, the first operation takes effect on the first posedge with rst high.

Structure
REQ-032 Shared package pc_pkg holds the op-select enum (OP_NONE, OP_INC, OP_LD, OP_CALL, OP_RET) and the priority-encode function.
REQ-033 Sub-module ras_lifo (parametrised ADDR_WIDTH, STACK_DEPTH; push, pop, data, depth, full, empty) holds the stack; pc_unit owns out, the error flags and op decode.

Verification (ADDR_WIDTH=13, STACK_DEPTH=4)
REQ-034 Reset, then cen for 3 cycles -> out=3; ld in=0x1FFF, then cen -> out=0x0000 (wrap).
REQ-035 out=0x0010, call in=0x0100 -> out=0x0100, depth=1; ret -> out=0x0011, depth=0, empty=1.
REQ-036 Four nested calls fill the stack -> full=1; a fifth call in=0x0AAA -> out, depth unchanged, overflow=1; clr_err -> overflow=0.
REQ-037 ret with depth=0 -> out unchanged, underflow=1; ret+clr_err in the same cycle -> underflow stays 1.
REQ-038 Simultaneous ret, call, ld, cen with depth=2 -> only the pop occurs (depth=1, out=top entry); call+ld+cen -> only the call occurs.
REQ-039 rst pulsed low between clock edges with depth=3 -> out=0 and depth=0 immediately; next call pushes into entry 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: operation select and
// the fixed-priority request encoder.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_LD,
        OP_CALL,
        OP_RET
    } op_e;

    // Only one operation runs per cycle; ret outranks call, call outranks ld, ld outranks cen.
    function automatic op_e selectOp(input logic cen, input logic ld,
                                     input logic call, input logic ret);
        op_e op;
        if (ret)       op = OP_RET;
        else if (call) op = OP_CALL;
        else if (ld)   op = OP_LD;
        else if (cen)  op = OP_INC;
        else           op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/ras_lifo.sv
// Return-address stack: a LIFO of ADDR_WIDTH-bit entries with a registered
// occupancy count; storage itself is not reset.
module ras_lifo
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 13,
    parameter int STACK_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_WIDTH-1:0]              push_data,
    output logic [ADDR_WIDTH-1:0]              data,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = $clog2(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]         depth_q, depth_d;
    logic [IW-1:0]         wrIdx, topIdx;
    logic                  doPush, doPop;

    assign full   = (depth_q == DW'(STACK_DEPTH));
    assign empty  = (depth_q == '0);
    assign depth  = depth_q;
    assign wrIdx  = IW'(depth_q);
    assign topIdx = IW'(depth_q - DW'(1));
    assign data   = mem[topIdx];

    // Requests that would over- or under-run the stack are dropped here as well.
    assign doPop  = pop && !empty;
    assign doPush = push && !full && !pop;

    always_comb begin
        depth_d = depth_q;
        if (doPush) begin
            depth_d = depth_q + DW'(1);
        end else if (doPop) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrIdx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, absolute load, call/return through a
// return-address stack, and sticky overflow/underflow flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 13,
    parameter int STACK_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cen,
    input  logic                               ld,
    input  logic                               call,
    input  logic                               ret,
    input  logic                               clr_err,
    input  logic [ADDR_WIDTH-1:0]              in,
    output logic [ADDR_WIDTH-1:0]              out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty,
    output logic                               overflow,
    output logic                               underflow
);

    op_e                   opSel;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] nextSeq, stackTop;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  stackPush, stackPop;
    logic                  stackFull, stackEmpty;

    assign opSel   = selectOp(cen, ld, call, ret);
    assign nextSeq = pc_q + ADDR_WIDTH'(1);

    ras_lifo #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (stackPush),
        .pop       (stackPop),
        .push_data (nextSeq),
        .data      (stackTop),
        .depth     (depth),
        .full      (stackFull),
        .empty     (stackEmpty)
    );

    // Error sets are evaluated after the clear so a same-cycle error wins.
    always_comb begin
        pc_d      = pc_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        stackPush = 1'b0;
        stackPop  = 1'b0;
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        case (opSel)
            OP_INC: pc_d = nextSeq;
            OP_LD:  pc_d = in;
            OP_CALL: begin
                if (stackFull) begin
                    ovf_d = 1'b1;
                end else begin
                    stackPush = 1'b1;
                    pc_d      = in;
                end
            end
            OP_RET: begin
                if (stackEmpty) begin
                    unf_d = 1'b1;
                end else begin
                    stackPop = 1'b1;
                    pc_d     = stackTop;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out       = pc_q;
    assign full      = stackFull;
    assign empty     = stackEmpty;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with a 13-bit PC and a
// four-entry return stack.
module tb_pc_unit;

    localparam int AW = 13;
    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cen = 1'b0;
    logic          ld = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          clr_err = 1'b0;
    logic [AW-1:0] in = '0;
    logic [AW-1:0] out;
    logic [DW-1:0] depth;
    logic          full, empty, overflow, underflow;

    int vectors = 0;
    int miscompares = 0;

    pc_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .ld        (ld),
        .call      (call),
        .ret       (ret),
        .clr_err   (clr_err),
        .in        (in),
        .out       (out),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of requests at the falling edge; returns 1ns after the rising edge.
    task automatic step(input logic c, input logic l, input logic ca, input logic r,
                        input logic ce, input logic [AW-1:0] target);
        @(negedge clk);
        cen = c; ld = l; call = ca; ret = r; clr_err = ce; in = target;
        @(posedge clk);
        #1;
        cen = 1'b0; ld = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0; in = '0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (out !== 13'h0000) begin miscompares++; $display("[TB] FAIL reset_out got %h want %h", out, 13'h0000); end
        vectors++;
        if (depth !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_depth got %0d want 0", depth); end
        vectors++;
        if ({full, empty, overflow, underflow} !== 4'b0100) begin
            miscompares++; $display("[TB] FAIL reset_flags got %b want 0100", {full, empty, overflow, underflow});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_increment();
        repeat (3) step(1, 0, 0, 0, 0, '0);
        vectors++;
        if (out !== 13'h0003) begin miscompares++; $display("[TB] FAIL inc3 got %h want %h", out, 13'h0003); end
        step(0, 1, 0, 0, 0, 13'h1FFF);
        vectors++;
        if (out !== 13'h1FFF) begin miscompares++; $display("[TB] FAIL ld_max got %h want %h", out, 13'h1FFF); end
        step(1, 0, 0, 0, 0, '0);
        vectors++;
        if (out !== 13'h0000) begin miscompares++; $display("[TB] FAIL inc_wrap got %h want %h", out, 13'h0000); end
        step(0, 0, 0, 0, 0, 13'h0555);
        step(0, 0, 0, 0, 0, 13'h0555);
        vectors++;
        if (out !== 13'h0000) begin miscompares++; $display("[TB] FAIL idle_hold got %h want %h", out, 13'h0000); end
    endtask

    task automatic test_call_ret();
        step(0, 1, 0, 0, 0, 13'h0010);
        step(0, 0, 1, 0, 0, 13'h0100);
        vectors++;
        if (out !== 13'h0100) begin miscompares++; $display("[TB] FAIL call_out got %h want %h", out, 13'h0100); end
        vectors++;
        if (depth !== 3'd1) begin miscompares++; $display("[TB] FAIL call_depth got %0d want 1", depth); end
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0011) begin miscompares++; $display("[TB] FAIL ret_out got %h want %h", out, 13'h0011); end
        vectors++;
        if (depth !== 3'd0 || empty !== 1'b1) begin
            miscompares++; $display("[TB] FAIL ret_depth got %0d/%b want 0/1", depth, empty);
        end
        // Return address wraps when calling from the top of the address space.
        step(0, 1, 0, 0, 0, 13'h1FFF);
        step(0, 0, 1, 0, 0, 13'h0005);
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0000) begin miscompares++; $display("[TB] FAIL call_wrap got %h want %h", out, 13'h0000); end
        step(0, 1, 0, 0, 0, 13'h0011);
    endtask

    task automatic test_overflow();
        step(0, 0, 1, 0, 0, 13'h0200);
        step(0, 0, 1, 0, 0, 13'h0300);
        step(0, 0, 1, 0, 0, 13'h0400);
        step(0, 0, 1, 0, 0, 13'h0500);
        vectors++;
        if (depth !== 3'd4 || full !== 1'b1 || empty !== 1'b0) begin
            miscompares++; $display("[TB] FAIL fill got depth %0d full %b empty %b want 4 1 0", depth, full, empty);
        end
        step(0, 0, 1, 0, 0, 13'h0AAA);
        vectors++;
        if (out !== 13'h0500 || depth !== 3'd4) begin
            miscompares++; $display("[TB] FAIL ovf_hold got %h/%0d want 0500/4", out, depth);
        end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_set got %b want 1", overflow); end
        step(0, 0, 0, 0, 1, '0);
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_clr got %b want 0", overflow); end
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0401) begin miscompares++; $display("[TB] FAIL pop4 got %h want %h", out, 13'h0401); end
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0301) begin miscompares++; $display("[TB] FAIL pop3 got %h want %h", out, 13'h0301); end
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0201) begin miscompares++; $display("[TB] FAIL pop2 got %h want %h", out, 13'h0201); end
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0012 || depth !== 3'd0) begin
            miscompares++; $display("[TB] FAIL pop1 got %h/%0d want 0012/0", out, depth);
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0012 || depth !== 3'd0) begin
            miscompares++; $display("[TB] FAIL unf_hold got %h/%0d want 0012/0", out, depth);
        end
        vectors++;
        if (underflow !== 1'b1) begin miscompares++; $display("[TB] FAIL unf_set got %b want 1", underflow); end
        step(0, 0, 0, 1, 1, '0);
        vectors++;
        if (underflow !== 1'b1) begin miscompares++; $display("[TB] FAIL unf_set_wins got %b want 1", underflow); end
        step(0, 0, 0, 0, 1, '0);
        vectors++;
        if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL unf_clr got %b want 0", underflow); end
    endtask

    task automatic test_priority();
        step(0, 1, 0, 0, 0, 13'h0020);
        step(0, 0, 1, 0, 0, 13'h0040);
        step(0, 0, 1, 0, 0, 13'h0060);
        step(1, 1, 1, 1, 0, 13'h0777);
        vectors++;
        if (out !== 13'h0041 || depth !== 3'd1) begin
            miscompares++; $display("[TB] FAIL prio_ret got %h/%0d want 0041/1", out, depth);
        end
        step(1, 1, 1, 0, 0, 13'h0123);
        vectors++;
        if (out !== 13'h0123 || depth !== 3'd2) begin
            miscompares++; $display("[TB] FAIL prio_call got %h/%0d want 0123/2", out, depth);
        end
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0042) begin miscompares++; $display("[TB] FAIL prio_pushed got %h want %h", out, 13'h0042); end
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0021 || depth !== 3'd0) begin
            miscompares++; $display("[TB] FAIL prio_bottom got %h/%0d want 0021/0", out, depth);
        end
        step(1, 1, 0, 0, 0, 13'h0050);
        vectors++;
        if (out !== 13'h0050) begin miscompares++; $display("[TB] FAIL prio_ld got %h want %h", out, 13'h0050); end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 1, 0, '0);
        step(0, 0, 1, 0, 0, 13'h0100);
        step(0, 0, 1, 0, 0, 13'h0200);
        step(0, 0, 1, 0, 0, 13'h0300);
        vectors++;
        if (depth !== 3'd3 || underflow !== 1'b1) begin
            miscompares++; $display("[TB] FAIL pre_rst got %0d/%b want 3/1", depth, underflow);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (out !== 13'h0000 || depth !== 3'd0 || empty !== 1'b1) begin
            miscompares++; $display("[TB] FAIL async_rst got %h/%0d/%b want 0000/0/1", out, depth, empty);
        end
        vectors++;
        if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL async_rst_unf got %b want 0", underflow); end
        #1;
        rst = 1'b1;
        step(0, 0, 1, 0, 0, 13'h0700);
        vectors++;
        if (out !== 13'h0700 || depth !== 3'd1) begin
            miscompares++; $display("[TB] FAIL post_rst_call got %h/%0d want 0700/1", out, depth);
        end
        step(0, 0, 0, 1, 0, '0);
        vectors++;
        if (out !== 13'h0001 || depth !== 3'd0) begin
            miscompares++; $display("[TB] FAIL post_rst_ret got %h/%0d want 0001/0", out, depth);
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
